button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter COUNT_SIZE, default 24: width of the internal hold/gap timer.
REQ-002 Parameter LONG_LIMIT, default 24'd5999999: hold cycles that qualify as a long press (0.5 s at 12 MHz).
REQ-003 Parameter GAP_LIMIT, default 24'd2999999: maximum release-to-press gap, in cycles, for a double click.
REQ-004 clock_in  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 button_in  input  1  debounced button level (1 = pressed), asynchronous to clock_in.
REQ-007 press_pulse  output  1  one-cycle pulse on each press.
REQ-008 release_pulse  output  1  one-cycle pulse on each release.
REQ-009 click_pulse  output  1  one-cycle pulse on a completed single short click.
REQ-010 double_pulse  output  1  one-cycle pulse on a completed double click.
REQ-011 long_pulse  output  1  one-cycle pulse when hold time reaches LONG_LIMIT.
REQ-012 button_held  output  1  registered synchronized button level.
REQ-013 press_count  output  8  running count of press_pulse events.

Function
REQ-014 button_in SHALL pass through a two-flop synchronizer (s1, s2) followed by a history flop s3; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-015 All outputs SHALL be registered; press_pulse/release_pulse SHALL assert on the 3rd rising edge after button_in is first sampled at its new level.
REQ-016 button_held SHALL equal s3.
REQ-017 FSM states: IDLE, PRESSED1, WAIT_GAP, PRESSED2, LONG_HELD.
REQ-018 IDLE + rise -> PRESSED1; press_pulse; timer cleared to 0.
REQ-019 PRESSED1: timer increments each cycle; fall -> WAIT_GAP, release_pulse, timer cleared; timer == LONG_LIMIT with no fall -> LONG_HELD, long_pulse.
REQ-020 LONG_HELD + fall -> IDLE; release_pulse; no click_pulse.
REQ-021 WAIT_GAP: timer increments; rise -> PRESSED2, press_pulse; timer == GAP_LIMIT with no rise -> IDLE, click_pulse.
REQ-022 PRESSED2 + fall -> IDLE; release_pulse and double_pulse in the same cycle; no long detection in PRESSED2.
REQ-023 Simultaneous events: in PRESSED1, fall takes priority over LONG_LIMIT; in WAIT_GAP, rise takes priority over GAP_LIMIT.
REQ-024 The timer SHALL never wrap; it holds at its limit and is cleared on every state entry.
REQ-025 Timing: long_pulse asserts LONG_LIMIT+1 cycles after press_pulse; click_pulse asserts GAP_LIMIT+1 cycles after release_pulse.
REQ-026 press_count SHALL increment by 1 on each press_pulse cycle and wrap 255 -> 0.
REQ-027 At most one of click_pulse, double_pulse, long_pulse SHALL be high in any cycle.

Reset
REQ-028 While reset is 0 at a rising edge: state = IDLE; timer, s1/s2/s3, press_count and all outputs = 0.
REQ-029 Reset mid-operation SHALL abort the sequence with no pulse in the cycle after release.
REQ-030 If button_in is high at reset release, press_pulse SHALL assert on the 3rd edge after release.

Configuration
REQ-031 Macro BUTTON_EVENT_DOUBLE_EN defined: full FSM per REQ-017..REQ-023.
REQ-032 Macro undefined: WAIT_GAP and PRESSED2 absent; PRESSED1 + fall -> IDLE with release_pulse and click_pulse in the same cycle; double_pulse tied 0; GAP_LIMIT unused.

Verification (LONG_LIMIT=20, GAP_LIMIT=10, DOUBLE_EN defined unless noted)
REQ-033 button_in high 5 cycles, then low -> press_pulse at edge 3, release_pulse 5 edges later, click_pulse 11 cycles after release_pulse, press_count = 1.
REQ-034 High 5 / low 4 / high 5 / low -> two press_pulse, two release_pulse, double_pulse with the second release_pulse, no click_pulse.
REQ-035 High 40 cycles -> long_pulse 21 cycles after press_pulse, release_pulse on fall, no click_pulse or double_pulse.
REQ-036 Second rise synchronized in the cycle the gap timer equals 10 -> PRESSED2 entered, press_pulse, no click_pulse.
REQ-037 reset low for 1 cycle during PRESSED1 -> all outputs 0, state IDLE, press_count 0; a held button yields press_pulse 3 edges after release.
REQ-038 Macro undefined, 256 short clicks -> 256 click_pulse, double_pulse never high, press_count back at 0.

Source files
------------

// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
//
// Turns a debounced push-button level into one-cycle event pulses: press,
// release, single click, double click and long press, plus the synchronized
// button level and a running press counter.
//
// Optional feature: define BUTTON_EVENT_DOUBLE_EN to build the double-click
// detector (WAIT_GAP / PRESSED2 states). Without it, every short press is a
// single click reported together with its release, and GAP_LIMIT has no
// effect on behaviour.
//
// Parameters
//   COUNT_SIZE   width of the hold/gap timer
//   LONG_LIMIT   hold cycles that qualify as a long press
//   GAP_LIMIT    maximum release-to-press gap for a double click
//
// Ports
//   clock_in       in   system clock, rising edge
//   reset          in   synchronous, active-low reset
//   button_in      in   debounced button level (1 = pressed), asynchronous
//   press_pulse    out  one-cycle pulse per press
//   release_pulse  out  one-cycle pulse per release
//   click_pulse    out  one-cycle pulse per completed single click
//   double_pulse   out  one-cycle pulse per completed double click
//   long_pulse     out  one-cycle pulse when the hold time reaches LONG_LIMIT
//   button_held    out  synchronized button level
//   press_count    out  running count of presses, wraps 255 -> 0
// -----------------------------------------------------------------------------
module button_event #(
    parameter int                    COUNT_SIZE = 24,
    parameter logic [COUNT_SIZE-1:0] LONG_LIMIT = 24'd5999999,
    parameter logic [COUNT_SIZE-1:0] GAP_LIMIT  = 24'd2999999
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       button_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       click_pulse,
    output logic       double_pulse,
    output logic       long_pulse,
    output logic       button_held,
    output logic [7:0] press_count
);

    // The timer saturates at the larger of the two limits so it can never
    // wrap, whichever state is counting.
    localparam logic [COUNT_SIZE-1:0] TIMER_MAX =
        (LONG_LIMIT > GAP_LIMIT) ? LONG_LIMIT : GAP_LIMIT;
    localparam logic [COUNT_SIZE-1:0] TIMER_ONE = {{(COUNT_SIZE-1){1'b0}}, 1'b1};

`ifdef BUTTON_EVENT_DOUBLE_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED1  = 3'd1,
        WAIT_GAP  = 3'd2,
        PRESSED2  = 3'd3,
        LONG_HELD = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED1  = 2'd1,
        LONG_HELD = 2'd2
    } state_t;
`endif

    state_t                state_reg;
    logic [COUNT_SIZE-1:0] timer_reg;
    logic                  s1_reg;
    logic                  s2_reg;
    logic                  s3_reg;
    logic                  rise;
    logic                  fall;

    // Two-flop synchronizer (s1, s2) plus a history flop (s3) for edge detect.
    always_ff @(posedge clock_in) begin
        if (!reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= button_in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign rise        = s2_reg & ~s3_reg;
    assign fall        = ~s2_reg & s3_reg;
    assign button_held = s3_reg;

    // Event FSM. Every pulse output defaults low each cycle, so each one is
    // high for exactly the cycle after the transition that produced it.
    always_ff @(posedge clock_in) begin
        if (!reset) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            double_pulse  <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            double_pulse  <= 1'b0;
            long_pulse    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    timer_reg <= '0;
                    if (rise) begin
                        state_reg   <= PRESSED1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end
                end
                PRESSED1: begin
                    // A release in the same cycle as the limit is still a click.
                    if (fall) begin
                        release_pulse <= 1'b1;
                        timer_reg     <= '0;
`ifdef BUTTON_EVENT_DOUBLE_EN
                        state_reg     <= WAIT_GAP;
`else
                        state_reg     <= IDLE;
                        click_pulse   <= 1'b1;
`endif
                    end else if (timer_reg == LONG_LIMIT) begin
                        state_reg  <= LONG_HELD;
                        long_pulse <= 1'b1;
                        timer_reg  <= '0;
                    end else if (timer_reg != TIMER_MAX) begin
                        timer_reg <= timer_reg + TIMER_ONE;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state_reg     <= IDLE;
                        release_pulse <= 1'b1;
                        timer_reg     <= '0;
                    end
                end
`ifdef BUTTON_EVENT_DOUBLE_EN
                WAIT_GAP: begin
                    // A second press landing exactly on the gap limit still
                    // counts as the start of a double click.
                    if (rise) begin
                        state_reg   <= PRESSED2;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                        timer_reg   <= '0;
                    end else if (timer_reg == GAP_LIMIT) begin
                        state_reg   <= IDLE;
                        click_pulse <= 1'b1;
                        timer_reg   <= '0;
                    end else if (timer_reg != TIMER_MAX) begin
                        timer_reg <= timer_reg + TIMER_ONE;
                    end
                end
                PRESSED2: begin
                    // No long-press detection on the second press.
                    if (fall) begin
                        state_reg     <= IDLE;
                        release_pulse <= 1'b1;
                        double_pulse  <= 1'b1;
                        timer_reg     <= '0;
                    end
                end
`endif
                default: begin
                    state_reg <= IDLE;
                    timer_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// -----------------------------------------------------------------------------
// tb_button_event
//
// Directed and randomized button waveforms for button_event (LONG_LIMIT=20,
// GAP_LIMIT=10). A time-based reference model predicts every output each
// cycle: the synchronized level is the input delayed by the synchronizer, and
// click / double / long decisions are made from elapsed cycle counts since
// the last press or release event.
// -----------------------------------------------------------------------------
module tb_button_event;

    localparam int LONG = 20;
    localparam int GAP  = 10;

    logic       clk;
    logic       reset;
    logic       button_in;
    logic       press_pulse;
    logic       release_pulse;
    logic       click_pulse;
    logic       double_pulse;
    logic       long_pulse;
    logic       button_held;
    logic [7:0] press_count;

    button_event #(
        .COUNT_SIZE (24),
        .LONG_LIMIT (24'd20),
        .GAP_LIMIT  (24'd10)
    ) dut (
        .clock_in      (clk),
        .reset         (reset),
        .button_in     (button_in),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .click_pulse   (click_pulse),
        .double_pulse  (double_pulse),
        .long_pulse    (long_pulse),
        .button_held   (button_held),
        .press_count   (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model phases (time-based, not a copy of the DUT encoding).
    localparam int M_IDLE  = 0;
    localparam int M_HOLD1 = 1;
    localparam int M_GAP   = 2;
    localparam int M_HOLD2 = 3;
    localparam int M_LONG  = 4;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         ph     = M_IDLE;
    int         t_evt  = 0;
    int         n_click_obs  = 0;
    int         n_double_obs = 0;
    int         n_long_obs   = 0;
    logic       h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;   // inputs sampled 1, 2, 3 edges ago
    logic       e_press, e_release, e_click, e_double, e_long, e_held;
    logic [7:0] e_count = 8'd0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference model for one rising edge with inputs b (button) and r (reset).
    task automatic model_edge(input logic b, input logic r);
        logic rise, fall;
        cyc++;
        e_press = 1'b0; e_release = 1'b0; e_click = 1'b0;
        e_double = 1'b0; e_long = 1'b0;
        if (!r) begin
            h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
            ph = M_IDLE; e_count = 8'd0; e_held = 1'b0;
        end else begin
            rise   = h1 & ~h2;
            fall   = ~h1 & h2;
            e_held = h1;
            case (ph)
                M_IDLE: if (rise) begin
                    e_press = 1'b1; e_count = e_count + 8'd1;
                    ph = M_HOLD1; t_evt = cyc;
                end
                M_HOLD1: if (fall) begin
                    e_release = 1'b1;
`ifdef BUTTON_EVENT_DOUBLE_EN
                    ph = M_GAP; t_evt = cyc;
`else
                    e_click = 1'b1; ph = M_IDLE;
`endif
                end else if (cyc - t_evt == LONG + 1) begin
                    e_long = 1'b1; ph = M_LONG;
                end
                M_LONG: if (fall) begin
                    e_release = 1'b1; ph = M_IDLE;
                end
                M_GAP: if (rise) begin
                    e_press = 1'b1; e_count = e_count + 8'd1; ph = M_HOLD2;
                end else if (cyc - t_evt == GAP + 1) begin
                    e_click = 1'b1; ph = M_IDLE;
                end
                M_HOLD2: if (fall) begin
                    e_release = 1'b1; e_double = 1'b1; ph = M_IDLE;
                end
                default: ph = M_IDLE;
            endcase
            h2 = h1; h1 = h0; h0 = b;
        end
    endtask

    // Drive one cycle, advance the model, compare all outputs at the negedge.
    task automatic step(input logic b, input logic r);
        button_in = b;
        reset     = r;
        @(posedge clk);
        model_edge(b, r);
        @(negedge clk);
        chk("press_pulse",   int'(press_pulse),   int'(e_press));
        chk("release_pulse", int'(release_pulse), int'(e_release));
        chk("click_pulse",   int'(click_pulse),   int'(e_click));
        chk("double_pulse",  int'(double_pulse),  int'(e_double));
        chk("long_pulse",    int'(long_pulse),    int'(e_long));
        chk("button_held",   int'(button_held),   int'(e_held));
        chk("press_count",   int'(press_count),   int'(e_count));
        chk("one_event",     int'($countones({click_pulse, double_pulse, long_pulse}) <= 1), 1);
        n_click_obs  += int'(click_pulse);
        n_double_obs += int'(double_pulse);
        n_long_obs   += int'(long_pulse);
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b1);
    endtask

    initial begin
        int c0, d0, l0;

        // Reset with the button released.
        hold_reset: for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("reset_count", int'(press_count), 0);
        hold(1'b0, 3);
        $display("reset done, cycle %0d", cyc);

        // Single short click.
        c0 = n_click_obs;
        hold(1'b1, 5); hold(1'b0, 20);
        chk("single_clicks", n_click_obs - c0, 1);
        chk("single_count", int'(press_count), 1);
        $display("single click done, cycle %0d", cyc);

        // Double click (one click and no double when the feature is off).
        c0 = n_click_obs; d0 = n_double_obs;
        hold(1'b1, 5); hold(1'b0, 4); hold(1'b1, 5); hold(1'b0, 20);
`ifdef BUTTON_EVENT_DOUBLE_EN
        chk("double_doubles", n_double_obs - d0, 1);
        chk("double_clicks", n_click_obs - c0, 0);
`else
        chk("double_doubles", n_double_obs - d0, 0);
        chk("double_clicks", n_click_obs - c0, 2);
`endif
        $display("double click done, cycle %0d", cyc);

        // Long press.
        c0 = n_click_obs; l0 = n_long_obs;
        hold(1'b1, 40); hold(1'b0, 20);
        chk("long_longs", n_long_obs - l0, 1);
        chk("long_clicks", n_click_obs - c0, 0);
        $display("long press done, cycle %0d", cyc);

        // Release landing on the long limit (release wins), then one cycle later.
        hold(1'b1, 21); hold(1'b0, 20);
        hold(1'b1, 22); hold(1'b0, 20);
        // Second press landing on the gap limit (press wins), then one cycle late.
        hold(1'b1, 4); hold(1'b0, 11); hold(1'b1, 4); hold(1'b0, 20);
        hold(1'b1, 4); hold(1'b0, 12); hold(1'b1, 4); hold(1'b0, 20);
        $display("boundary cases done, cycle %0d", cyc);

        // Reset in the middle of a press with the button held through it.
        hold(1'b1, 6);
        step(1'b1, 1'b0);
        chk("midreset_count", int'(press_count), 0);
        chk("midreset_held", int'(button_held), 0);
        hold(1'b1, 8); hold(1'b0, 20);
        $display("mid-press reset done, cycle %0d", cyc);

        // Randomized press/release lengths, occasional reset.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 15) == 0) step(1'(($urandom_range(0, 1))), 1'b0);
            hold(1'b1, int'($urandom_range(1, 28)));
            hold(1'b0, int'($urandom_range(1, 16)));
        end
        hold(1'b0, 30);
        $display("random sequence done, cycle %0d", cyc);

        // 256 short clicks wrap the press counter back to its start value.
        c0 = n_click_obs; d0 = n_double_obs;
        l0 = int'(press_count);
        for (int k = 0; k < 256; k++) begin
            hold(1'b1, 3); hold(1'b0, 14);
        end
        chk("wrap_clicks", n_click_obs - c0, 256);
        chk("wrap_doubles", n_double_obs - d0, 0);
        chk("wrap_count", int'(press_count), l0);
        $display("256 clicks done, cycle %0d", cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
